// File: rtl/dp_scram.sv
// dp_scram: simple dual-port RAM with one write port and one read port.
// The read port is synchronous, enable-gated and read-before-write.
module dp_scram #(
   parameter int DWIDTH = 16,
   parameter int AWIDTH = 6
) (
   input  logic              clk,
   input  logic              areset_n,
   input  logic [AWIDTH-1:0] addr0,
   input  logic [DWIDTH-1:0] data0,
   input  logic              we0,
   input  logic [AWIDTH-1:0] addr1,
   input  logic              re1,
   output logic [DWIDTH-1:0] q1
);

   localparam int DEPTH = 2 ** AWIDTH;

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] q1_q;
   logic [DWIDTH-1:0] q1_d;

   // Storage is never reset so the array maps onto plain RAM
   always_ff @(posedge clk) begin
      if (we0) begin
         mem_q[addr0] <= data0;
      end
   end

   always_comb begin
      q1_d = q1_q;
      if (re1) begin
         q1_d = mem_q[addr1];
      end
   end

   // Same-edge write lands after this sample, giving the old word
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         q1_q <= '0;
      end else begin
         q1_q <= q1_d;
      end
   end

   assign q1 = q1_q;

endmodule

// File: tb/tb_dp_scram.sv
// tb_dp_scram: directed checks of dp_scram write, read,
// gating, collision, streaming and reset behaviour.
module tb_dp_scram;

   logic        clk;
   logic        areset_n;
   logic [5:0]  addr0;
   logic [15:0] data0;
   logic        we0;
   logic [5:0]  addr1;
   logic        re1;
   logic [15:0] q1;

   int total;
   int bad;

   dp_scram #(.DWIDTH(16), .AWIDTH(6)) dut (
      .clk      (clk),
      .areset_n (areset_n),
      .addr0    (addr0),
      .data0    (data0),
      .we0      (we0),
      .addr1    (addr1),
      .re1      (re1),
      .q1       (q1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [15:0] got,
                      input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] sweep_v(input int i);
      logic [15:0] v;
      v = 16'(i);
      return v * 16'h0101;
   endfunction

   initial begin
      total    = 0;
      bad      = 0;
      areset_n = 1'b0;
      addr0    = '0;
      data0    = '0;
      we0      = 1'b0;
      addr1    = '0;
      re1      = 1'b0;
      #2;
      chk("rst_init", q1, 16'h0000);
      step();
      areset_n = 1'b1;

      addr0 = 6'd0;
      data0 = 16'hBEEF;
      we0   = 1'b1;
      step();
      we0   = 1'b0;
      addr1 = 6'd0;
      re1   = 1'b1;
      step();
      re1 = 1'b0;
      chk("pre_rst", q1, 16'hBEEF);
      areset_n = 1'b0;
      #2;
      chk("rst_async", q1, 16'h0000);
      step();
      areset_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_hold", q1, 16'h0000);
      end

      for (int i = 0; i < 64; i++) begin
         addr0 = 6'(i);
         data0 = sweep_v(i);
         we0   = 1'b1;
         step();
      end
      we0 = 1'b0;
      re1 = 1'b1;
      for (int i = 0; i < 64; i++) begin
         addr1 = 6'(i);
         step();
         chk("sweep", q1, sweep_v(i));
      end
      addr1 = 6'd0;
      step();
      chk("wrap_0", q1, 16'h0000);

      addr1 = 6'd5;
      step();
      chk("gate_rd5", q1, 16'h0505);
      re1   = 1'b0;
      addr1 = 6'd9;
      step();
      chk("gate_hold", q1, 16'h0505);
      step();
      chk("gate_hold2", q1, 16'h0505);
      re1 = 1'b1;
      step();
      chk("gate_rd9", q1, 16'h0909);

      re1   = 1'b0;
      addr0 = 6'd7;
      data0 = 16'h1111;
      we0   = 1'b1;
      step();
      data0 = 16'h2222;
      addr1 = 6'd7;
      re1   = 1'b1;
      step();
      chk("rdw_old", q1, 16'h1111);
      we0 = 1'b0;
      step();
      chk("rdw_new", q1, 16'h2222);

      for (int k = 1; k <= 64; k++) begin
         addr0 = 6'(k % 64);
         data0 = 16'hA000 + 16'(k);
         we0   = 1'b1;
         addr1 = 6'((k - 1) % 64);
         re1   = 1'b1;
         step();
         if (k >= 2) chk("stream", q1, 16'hA000 + 16'(k - 1));
      end
      we0 = 1'b0;
      re1 = 1'b0;
      step();

      areset_n = 1'b0;
      #2;
      chk("mid_rst", q1, 16'h0000);
      #3;
      areset_n = 1'b1;
      step();
      chk("mid_rst_hold", q1, 16'h0000);
      re1   = 1'b1;
      addr1 = 6'd5;
      step();
      chk("keep_5", q1, 16'hA005);
      addr1 = 6'd0;
      step();
      chk("keep_0", q1, 16'hA040);
      addr1 = 6'd63;
      step();
      chk("keep_63", q1, 16'hA03F);
      addr1 = 6'd7;
      step();
      chk("keep_7", q1, 16'hA007);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
